// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the RX sampler, the RX deframer and the
// holding register.
//   uart_state_e       : deframer FSM states
//   DATA_BITS_DEFAULT  : default number of data bits per frame
//   PARITY_EVEN/ODD    : parity-mode selector values
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } uart_state_e;

  localparam int unsigned DATA_BITS_DEFAULT = 8;

  localparam int unsigned PARITY_EVEN = 0;
  localparam int unsigned PARITY_ODD  = 1;

endpackage : uart_pkg

// File: rtl/uart_rx_outreg.sv
// -----------------------------------------------------------------------------
// uart_rx_outreg
// One-entry valid/ready holding register with overrun detection.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_valid  : a completed word is offered this cycle
//   load_data   : the offered word
//   data_out    : held word, stable while data_valid and no transfer
//   data_valid  : register is full
//   data_ready  : consumer accepts (transfer on data_valid && data_ready)
//   overrun     : one-cycle pulse, offered word dropped because register full
// A word offered in the same cycle as a transfer replaces the outgoing one.
// -----------------------------------------------------------------------------
module uart_rx_outreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             transfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    transfer  = valid_q && data_ready;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_valid) begin
      if (!valid_q || transfer) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule : uart_rx_outreg

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
// Rebuilds bytes from the per-bit sample stream of the UART RX sampler.
// Frame: start(0), DATA_BITS data bits LSB first, [parity], stop(1).
// Optional feature macro: UART_PARITY_EN (adds PARITY state + parity_error).
//   sampling_clock : clock, same domain as the sampler
//   reset_n        : asynchronous active-low reset
//   sampled_rx     : sampled bit, valid when bit_strobe = 1
//   bit_strobe     : one-cycle pulse per sampled bit
//   data_out       : received byte, stable while data_valid
//   data_valid     : byte available
//   data_ready     : consumer accepts
//   framing_error  : one-cycle pulse, stop bit sampled as 0
//   overrun_error  : one-cycle pulse, byte dropped because output was full
//   busy           : FSM not in IDLE
//   parity_error   : (UART_PARITY_EN only) one-cycle pulse with the delivery
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int unsigned DATA_BITS  = uart_pkg::DATA_BITS_DEFAULT,
  parameter int unsigned PARITY_ODD = uart_pkg::PARITY_EVEN
) (
  input  logic                 sampling_clock,
  input  logic                 reset_n,
  input  logic                 sampled_rx,
  input  logic                 bit_strobe,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
`ifdef UART_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  import uart_pkg::*;

  localparam int unsigned    IDX_W    = $clog2(DATA_BITS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  // Elaboration-time guard on the configuration range.
  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_deframer: unsupported DATA_BITS/PARITY_ODD");
  end

  uart_state_e          state_q, state_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 framing_q, framing_d;
  logic                 frame_done;

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic parity_bit_q, parity_bit_d;
  logic parity_err_q, parity_err_d;
`endif

  // State register
  always_ff @(posedge sampling_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      framing_q    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      framing_q    <= framing_d;
`ifdef UART_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: only strobe cycles advance the frame
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_PARITY_EN
    parity_bit_d = parity_bit_q;
`endif
    if (bit_strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (!sampled_rx) begin
            bit_idx_d = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          // Shift in at the top so the first data bit ends up in bit 0
          shift_d   = {sampled_rx, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          parity_bit_d = sampled_rx;
          state_d      = ST_STOP;
        end
`endif
        ST_STOP:  state_d = sampled_rx ? ST_IDLE : ST_BREAK;
        // Hold off until the line returns high so a held-low line is not
        // taken as a stream of start bits.
        ST_BREAK: if (sampled_rx) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = bit_strobe && (state_q == ST_STOP) && sampled_rx;
    framing_d  = bit_strobe && (state_q == ST_STOP) && !sampled_rx;
`ifdef UART_PARITY_EN
    parity_err_d = frame_done && (parity_bit_q != ((^shift_q) ^ PAR_ODD));
`endif
  end

  uart_rx_outreg #(
    .WIDTH (DATA_BITS)
  ) u_outreg (
    .clk        (sampling_clock),
    .rst_n      (reset_n),
    .load_valid (frame_done),
    .load_data  (shift_q),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun_error)
  );

  assign framing_error = framing_q;
`ifdef UART_PARITY_EN
  assign parity_error  = parity_err_q;
`endif

endmodule : uart_rx_deframer
